// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the wait-state memory stage.
// Holds the access FSM encoding, memory index sizing and the MEM/WB bubble values.
package mem_stage_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } state_e;

   // Word-index width for a memory of the given depth
   function automatic int unsigned word_aw(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   localparam logic BubbleWbEn   = 1'b0;
   localparam logic BubbleMemREn = 1'b0;

endpackage

// File: rtl/data_mem_sync.sv
// Word-addressed data memory: synchronous write, combinational read, window decode.
// Addresses are bytes relative to BASE_ADDR; the low two bits are ignored.
module data_mem_sync import mem_stage_pkg::*; #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_WORDS = 64,
   parameter int unsigned BASE_ADDR = 1024
) (
   input  logic              clk,
   input  logic              we,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              in_range
);

   localparam int unsigned AW = word_aw(MEM_WORDS);
   localparam logic [DATA_W-1:0] BaseAddr = DATA_W'(BASE_ADDR);

   logic [DATA_W-1:0] offset;
   logic [DATA_W-1:0] word_off;
   logic [DATA_W-1:0] mem_q [MEM_WORDS];

   assign offset   = addr - BaseAddr;
   assign word_off = offset >> 2;
   // Any word offset bit above the index means the address is past the window
   assign in_range = (addr >= BaseAddr) && (word_off[DATA_W-1:AW] == '0);

   always_ff @(posedge clk) begin
      if (we && in_range) begin
         mem_q[word_off[AW-1:0]] <= wdata;
      end
   end

   assign rdata = in_range ? mem_q[word_off[AW-1:0]] : '0;

endmodule

// File: rtl/mem_stage_ws.sv
// MEM stage with configurable wait states: runs loads/stores, stalls upstream while
// an access is in flight, and registers the result into the MEM/WB register.
module mem_stage_ws import mem_stage_pkg::*; #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned REG_AW      = 4,
   parameter int unsigned MEM_WORDS   = 64,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              mem_w_en_in,
   input  logic              mem_r_en_in,
   input  logic              wb_en_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [REG_AW-1:0] dest_in,
   output logic              stall,
   output logic              wb_en,
   output logic              mem_r_en,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] mem_read_value,
   output logic [REG_AW-1:0] dest,
   output logic              addr_err
);

   localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);
   localparam bit         HasWait = (WAIT_CYCLES != 0);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              access, is_load, complete, mem_we, in_range;
   logic [DATA_W-1:0] rdata;

   logic              wb_en_q, wb_en_d;
   logic              mem_r_en_q, mem_r_en_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] mrv_q, mrv_d;
   logic [REG_AW-1:0] dest_q, dest_d;
   logic              addr_err_q, addr_err_d;

   assign access   = mem_r_en_in | mem_w_en_in;
   // A simultaneous read+write is a store
   assign is_load  = mem_r_en_in & ~mem_w_en_in;
   assign complete = access & (!HasWait | ((state_q == StWait) && (cnt_q == WaitCnt)));
   assign stall    = access & ~complete;
   assign mem_we   = complete & mem_w_en_in & ~flush & ~rst;

   data_mem_sync #(
      .DATA_W    (DATA_W),
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (BASE_ADDR)
   ) u_data_mem (
      .clk      (clk),
      .we       (mem_we),
      .addr     (alu_result_in),
      .wdata    (val_rm),
      .rdata    (rdata),
      .in_range (in_range)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (access && HasWait) begin
                  state_d = StWait;
                  cnt_d   = 4'd1;
               end
            end
            StWait: begin
               if (cnt_q < WaitCnt) begin
                  cnt_d = cnt_q + 4'd1;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      wb_en_d    = wb_en_q;
      mem_r_en_d = mem_r_en_q;
      alu_d      = alu_q;
      mrv_d      = mrv_q;
      dest_d     = dest_q;
      addr_err_d = addr_err_q;
      if (flush || stall) begin
         wb_en_d    = BubbleWbEn;
         mem_r_en_d = BubbleMemREn;
      end else begin
         // Not stalled: either a non-memory op or an access completing now
         wb_en_d    = wb_en_in;
         mem_r_en_d = is_load;
         alu_d      = alu_result_in;
         dest_d     = dest_in;
         if (is_load) begin
            mrv_d = rdata;
         end
         if (access && !in_range) begin
            addr_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         alu_q      <= '0;
         mrv_q      <= '0;
         dest_q     <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_en_q    <= wb_en_d;
         mem_r_en_q <= mem_r_en_d;
         alu_q      <= alu_d;
         mrv_q      <= mrv_d;
         dest_q     <= dest_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign wb_en          = wb_en_q;
   assign mem_r_en       = mem_r_en_q;
   assign alu_result     = alu_q;
   assign mem_read_value = mrv_q;
   assign dest           = dest_q;
   assign addr_err       = addr_err_q;

endmodule
